// File: rtl/spiflash_read_ctrl.sv
// Single-bit SPI NOR read controller: wakes the flash with AB, then serves 32-bit word fetches
// with 03 reads, streaming sequential fetches under one chip-select.
module spiflash_read_ctrl #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned CSB_HIGH_MIN = 4,
  parameter int unsigned WAKE_CYCLES  = 8,
  parameter int unsigned HOLD_MAX     = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0,
  input  logic        flash_io1
);

  localparam int unsigned GapCycles = (CSB_HIGH_MIN > WAKE_CYCLES) ? CSB_HIGH_MIN : WAKE_CYCLES;
  localparam logic [15:0] DivLast   = 16'(CLK_DIV - 1);
  localparam logic [15:0] GapLen    = 16'(GapCycles);
  localparam logic [15:0] DeselLen  = 16'(CSB_HIGH_MIN);
  localparam logic [15:0] HoldLen   = 16'(HOLD_MAX);

  typedef enum logic [2:0] {
    StIdle, StWake, StWakeGap, StCmd, StData, StResp, StHold, StDesel
  } state_e;

  state_e      state_q, state_d;
  logic        powered_q, powered_d;
  logic        alive_q;
  logic [23:0] addr_q, addr_d;
  logic [23:0] next_addr_q, next_addr_d;
  logic [30:0] shift_q, shift_d;
  logic [31:0] rx_q, rx_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        sck_q, sck_d;
  logic        csb_q, csb_d;
  logic        io0_q, io0_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic [23:0] req_word;
  logic        req_fire;
  logic        shifting;
  logic        word_done;
  logic [4:0]  last_bit;
  logic        start;
  logic [31:0] start_word;

  assign req_word  = req_addr & 24'hFFFFFC;
  assign busy      = (state_q != StIdle);
  assign flash_csb = csb_q;
  assign flash_clk = sck_q;
  assign flash_io0 = io0_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // In HOLD only a continuation of the stream is accepted; anything else closes the stream first.
  assign req_ready = alive_q &&
                     ((state_q == StIdle) || ((state_q == StHold) && (req_word == next_addr_q)));
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    powered_d   = powered_q;
    addr_d      = addr_q;
    next_addr_d = next_addr_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    sck_d       = sck_q;
    csb_d       = csb_q;
    io0_d       = io0_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    word_done   = 1'b0;
    start       = 1'b0;
    start_word  = '0;

    shifting = (state_q == StWake) || (state_q == StCmd) || (state_q == StData);
    last_bit = (state_q == StWake) ? 5'd7 : 5'd31;

    // Bit engine: SCK low then high for CLK_DIV clk each, MOSI changes at start of low phase.
    if (shifting) begin
      if (div_cnt_q == DivLast) begin
        div_cnt_d = '0;
        if (!sck_q) begin
          sck_d = 1'b1;
          rx_d  = {rx_q[30:0], flash_io1};
        end else begin
          sck_d = 1'b0;
          if (bit_cnt_q == last_bit) begin
            word_done = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
            io0_d     = shift_q[30];
            shift_d   = {shift_q[29:0], 1'b0};
          end
        end
      end else begin
        div_cnt_d = div_cnt_q + 16'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (req_fire) begin
          addr_d = req_word;
          csb_d  = 1'b0;
          start  = 1'b1;
          if (powered_q) begin
            state_d    = StCmd;
            start_word = {8'h03, req_word};
          end else begin
            state_d    = StWake;
            start_word = {8'hAB, 24'h000000};
          end
        end
      end
      StWake: begin
        if (word_done) begin
          state_d    = StWakeGap;
          csb_d      = 1'b1;
          io0_d      = 1'b0;
          wait_cnt_d = '0;
        end
      end
      StWakeGap: begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        if (wait_cnt_q + 16'd1 >= GapLen) begin
          state_d    = StCmd;
          powered_d  = 1'b1;
          csb_d      = 1'b0;
          start      = 1'b1;
          start_word = {8'h03, addr_q};
        end
      end
      StCmd: begin
        if (word_done) begin
          state_d = StData;
          start   = 1'b1;
        end
      end
      StData: begin
        if (word_done) begin
          state_d     = StResp;
          io0_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          next_addr_d = addr_q + 24'd4;
          wait_cnt_d  = '0;
          if (HOLD_MAX > 0) begin
            state_d = StHold;
          end else begin
            state_d = StDesel;
            csb_d   = 1'b1;
          end
        end
      end
      StHold: begin
        if (req_fire) begin
          state_d = StData;
          addr_d  = req_word;
          start   = 1'b1;
        end else if (req_valid || (wait_cnt_q + 16'd1 >= HoldLen)) begin
          state_d    = StDesel;
          csb_d      = 1'b1;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StDesel: begin
        wait_cnt_d = wait_cnt_q + 16'd1;
        if (wait_cnt_q + 16'd1 >= DeselLen) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      shift_d   = start_word[30:0];
      io0_d     = start_word[31];
      sck_d     = 1'b0;
      div_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      powered_q   <= 1'b0;
      alive_q     <= 1'b0;
      addr_q      <= '0;
      next_addr_q <= '0;
      shift_q     <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      wait_cnt_q  <= '0;
      sck_q       <= 1'b0;
      csb_q       <= 1'b1;
      io0_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      powered_q   <= powered_d;
      alive_q     <= 1'b1;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      sck_q       <= sck_d;
      csb_q       <= csb_d;
      io0_q       <= io0_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_spiflash_read_ctrl.sv
// Bench for spiflash_read_ctrl: behavioural SPI flash plus a table of fetches and a few
// hand-written sequences for stall, hold timeout and mid-transfer reset.
module tb_spiflash_read_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy;
  logic        flash_csb;
  logic        flash_clk;
  logic        flash_io0;
  logic        flash_io1 = 1'b0;

  always #5 clk = ~clk;

  spiflash_read_ctrl #(
    .CLK_DIV     (2),
    .CSB_HIGH_MIN(4),
    .WAKE_CYCLES (8),
    .HOLD_MAX    (16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .busy     (busy),
    .flash_csb(flash_csb),
    .flash_clk(flash_clk),
    .flash_io0(flash_io0),
    .flash_io1(flash_io1)
  );

  int n_pass = 0;
  int n_total = 0;

  // Flash model and bus monitor state
  logic        sck_prev = 1'b0;
  logic        csb_prev = 1'b1;
  int          sess_rises = 0;
  int          tot_rises = 0;
  int          high_len = 0;
  int          last_gap = 0;
  int          csb_falls = 0;
  int          ab_cnt = 0;
  int          cmd_cnt = 0;
  int          out_cnt = 0;
  logic [31:0] sess_cmd = '0;
  logic [23:0] rd_addr = '0;
  logic [23:0] cmd_addr = '0;
  logic [7:0]  out_sr = '0;
  logic        reading = 1'b0;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [7:0] k;
    if (a[23:3] == 21'h000020) begin
      k = {5'd0, a[2:0]} + 8'd1;
      return k * 8'h11;
    end
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  always @(negedge clk) begin
    if (!flash_csb && csb_prev) begin
      last_gap   = high_len;
      sess_rises = 0;
      reading    = 1'b0;
      csb_falls++;
    end
    if (flash_csb) high_len++;
    else high_len = 0;
    if (!flash_csb && flash_clk && !sck_prev) begin
      tot_rises++;
      if (sess_rises < 32) sess_cmd = {sess_cmd[30:0], flash_io0};
      sess_rises++;
      if (sess_rises == 8 && sess_cmd[7:0] == 8'hAB) ab_cnt++;
      if (sess_rises == 32 && sess_cmd[31:24] == 8'h03) begin
        cmd_cnt++;
        cmd_addr = sess_cmd[23:0];
        rd_addr  = sess_cmd[23:0];
        reading  = 1'b1;
        out_cnt  = 0;
      end
    end
    if (!flash_csb && !flash_clk && sck_prev && reading) begin
      if (out_cnt == 0) out_sr = flash_byte(rd_addr);
      flash_io1 = out_sr[7];
      out_sr    = {out_sr[6:0], 1'b0};
      out_cnt++;
      if (out_cnt == 8) begin
        out_cnt = 0;
        rd_addr = rd_addr + 24'd1;
      end
    end
    sck_prev = flash_clk;
    csb_prev = flash_csb;
  end

  typedef struct {
    string       name;
    logic [23:0] addr;
    logic [31:0] data;
    int          rises;
    int          ab;
    int          cmds;
    int          falls;
    logic [23:0] cmd_addr;
    int          min_gap;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_min(input string name, input int act, input int lo);
    n_total++;
    if (act >= lo) n_pass++;
    else $display("FAIL %s: got %0d, expected at least %0d", name, act, lo);
  endtask

  task automatic send_req(input logic [23:0] a, output bit ok);
    int t;
    t = 0;
    req_addr  = a;
    req_valid = 1'b1;
    #1;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    ok = req_ready;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic do_fetch(input vec_t v, input int stall);
    int          r0, a0, c0, f0, t;
    bit          ok, stable;
    logic [31:0] snap;
    r0 = tot_rises;
    a0 = ab_cnt;
    c0 = cmd_cnt;
    f0 = csb_falls;
    send_req(v.addr, ok);
    check({v.name, "/accept"}, 32'(ok), 32'd1);
    t = 0;
    while (!rsp_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({v.name, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (stall > 0) begin
      snap   = rsp_data;
      stable = 1'b1;
      repeat (stall) begin
        @(negedge clk);
        if (!(rsp_valid && rsp_data === snap && !flash_clk && !flash_csb)) stable = 1'b0;
      end
      check({v.name, "/stall_stable"}, 32'(stable), 32'd1);
    end
    check({v.name, "/data"}, rsp_data, v.data);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({v.name, "/rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
    check({v.name, "/sck_count"}, tot_rises - r0, v.rises);
    check({v.name, "/ab_sent"}, ab_cnt - a0, v.ab);
    check({v.name, "/cmd03_sent"}, cmd_cnt - c0, v.cmds);
    check({v.name, "/csb_falls"}, csb_falls - f0, v.falls);
    if (v.cmds > 0) check({v.name, "/cmd_addr"}, 32'(cmd_addr), 32'(v.cmd_addr));
    if (v.min_gap > 0) check_min({v.name, "/csb_gap"}, last_gap, v.min_gap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t extra;
    bit   ok;
    int   n, t, r0;

    vecs[0] = '{"cold",     24'h000100, 32'h44332211, 72, 1, 1, 2, 24'h000100, 8};
    vecs[1] = '{"seq",      24'h000104, 32'h88776655, 32, 0, 0, 0, 24'h000000, 0};
    vecs[2] = '{"nonseq",   24'h000200, 32'hA4A5A6A7, 64, 0, 1, 1, 24'h000200, 4};
    vecs[3] = '{"top",      24'hFFFFFC, 32'hA5A4A7A6, 64, 0, 1, 1, 24'hFFFFFC, 4};
    vecs[4] = '{"wrap",     24'h000000, 32'hA6A7A4A5, 32, 0, 0, 0, 24'h000000, 0};
    vecs[5] = '{"unalign",  24'h000103, 32'h44332211, 64, 0, 1, 1, 24'h000100, 4};

    // Reset values
    @(negedge clk);
    #1;
    check("rst/csb", 32'(flash_csb), 32'd1);
    check("rst/sck", 32'(flash_clk), 32'd0);
    check("rst/io0", 32'(flash_io0), 32'd0);
    check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst/rsp_data", rsp_data, 32'd0);
    check("rst/req_ready", 32'(req_ready), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) do_fetch(vecs[i], 0);

    // Stalled response, then an idle HOLD window until CSB rises
    extra = '{"stall", 24'h000300, 32'hA5A4A7A6, 64, 0, 1, 1, 24'h000300, 4};
    do_fetch(extra, 50);
    n = 0;
    while (!flash_csb && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("hold_timeout_cycles", n, 16);
    repeat (8) @(negedge clk);

    // Reset in the middle of the DATA phase
    r0 = tot_rises;
    send_req(24'h000100, ok);
    check("midrst/accept", 32'(ok), 32'd1);
    t = 0;
    while ((tot_rises - r0) < 40 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("midrst/in_data", 32'(tot_rises - r0 >= 40), 32'd1);
    resetn = 1'b0;
    #1;
    check("midrst/csb", 32'(flash_csb), 32'd1);
    check("midrst/sck", 32'(flash_clk), 32'd0);
    check("midrst/rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst/busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    extra = '{"rewake", 24'h000104, 32'h88776655, 72, 1, 1, 2, 24'h000104, 8};
    do_fetch(extra, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spiflash_read_ctrl.md
Name: spiflash_read_ctrl

Overview:
Clock-domain master that sequences an external single-bit SPI NOR flash (commands AB, 03) to serve 32-bit word fetches from an on-chip requester over a valid/ready interface. It issues a release-from-power-down (AB) on first use after reset, then 03 reads with a 24-bit address. Back-to-back sequential fetches continue streaming under the same chip-select without re-issuing the command.

Parameters:
CLK_DIV, 2, clk cycles per SCK half-period (>=1).
CSB_HIGH_MIN, 4, minimum clk cycles flash_csb held high between transactions.
WAKE_CYCLES, 8, clk cycles waited after AB deselect before first 03 (tRES).
HOLD_MAX, 16, clk cycles CSB is held low awaiting a sequential request; 0 disables continuation.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  fetch request valid
req_ready  out  1  request accepted when valid&ready
req_addr  in  24  byte address; bits [1:0] ignored (forced 0)
rsp_valid  out  1  rsp_data valid
rsp_ready  in  1  response consumed when valid&ready
rsp_data  out  32  fetched word, little-endian
busy  out  1  state != IDLE
flash_csb  out  1  flash chip select, active low
flash_clk  out  1  SCK, mode 0 (idles low)
flash_io0  out  1  MOSI
flash_io1  in  1  MISO

Behaviour:
- Reset (async on resetn low, any state): flash_csb=1, flash_clk=0, flash_io0=0, rsp_valid=0, rsp_data=0, req_ready=0 during reset, state=IDLE, powered=0, hold counter=0.
- States: IDLE, WAKE, WAKE_GAP, CMD, DATA, RESP, HOLD, DESEL.
- SCK: low for CLK_DIV clk, high for CLK_DIV clk per bit. MOSI updated while SCK low (at falling edge / start of low phase), MSB-first. MISO registered on the clk edge where flash_clk goes 0->1.
- req_ready=1 only in IDLE or HOLD. Request captured on valid&ready; addr latched with [1:0]=0.
- IDLE + request: if !powered -> WAKE (CSB low, shift 8'hAB, 8 SCK), then CSB high WAKE_GAP for max(CSB_HIGH_MIN, WAKE_CYCLES) clk, powered=1, -> CMD. If powered -> CMD directly.
- CMD: CSB low, shift 8'h03 then addr[23:16], [15:8], [7:0]: 32 SCK. -> DATA.
- DATA: 32 SCK, io0 held 0. Byte k (k=0..3) received MSB-first goes to rsp_data[8k+7:8k]. rsp_data updated only at end of DATA; -> RESP with rsp_valid=1.
- RESP: SCK stays low, CSB stays low, rsp_valid/rsp_data stable until rsp_ready. On handshake rsp_valid=0 next cycle; next_addr=addr+4 (mod 2^24); -> HOLD if HOLD_MAX>0 else DESEL.
- HOLD: CSB low, SCK low. Request with addr==next_addr -> DATA directly (no command, no CSB toggle). Request with other addr -> not accepted in HOLD (req_ready drops next cycle), -> DESEL; it is then accepted from IDLE. Counter reaching HOLD_MAX with no request -> DESEL. Request and timeout in same cycle: request wins.
- DESEL: CSB high for CSB_HIGH_MIN clk, -> IDLE. IDLE enforces no CSB low earlier.
- Wrap: addr 0xFFFFFC +4 = 0x000000 counts as sequential (flash address counter wraps identically).
- Reset mid-transaction: CSB high immediately, response dropped, powered=0 so next request re-issues AB.
- Exactly one outstanding request; no request queueing.

Test Plan:
- Cold fetch addr 0x000100, flash bytes 11 22 33 44 -> CSB low 8 SCK shifting 0xAB, CSB high >=8 clk, CSB low 64 SCK with MOSI 03 00 01 00, rsp_data=0x44332211.
- Second fetch 0x000104 within HOLD_MAX, bytes 55 66 77 88 -> no CSB toggle, exactly 32 SCK, rsp_data=0x88776655, no AB/03 re-sent.
- Non-sequential fetch 0x000200 from HOLD -> CSB high >=4 clk, 64 SCK with 03 00 02 00, no AB.
- rsp_ready held low 50 cycles -> rsp_valid and rsp_data stable, flash_clk static low, CSB low; HOLD_MAX idle afterwards -> CSB rises after 16 clk.
- Wrap: fetch 0xFFFFFC then 0x000000 -> second served by 32 SCK continuation; req_addr 0x000103 -> MOSI address 00 01 00.
- resetn pulsed low mid-DATA -> CSB=1, SCK=0, rsp_valid=0 immediately; next request starts with 0xAB.
